// File: rtl/dispatch_queue_pkg.sv
// Shared types for the decode-and-dispatch stage: functional-unit enum,
// decoded entry layout and RV opcode constants.
package dispatch_queue_pkg;

    // Decoded immediates are always built at this width; the top slices to XLEN.
    localparam int IMM_W = 64;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        LSU = 2'd1,
        BU  = 2'd2
    } e_functional_unit;

    typedef struct packed {
        e_functional_unit fu;
        logic [31:0]      insn;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [IMM_W-1:0] imm;
    } dispatch_entry_t;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    function automatic logic [IMM_W-1:0] sext32(input logic [31:0] v);
        return {{(IMM_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side poll handshake and dispatch-side valid/ready bundle.
// slave = the queue, master = whoever drives fetch and the reservation stations.
interface dispatch_queue_if
    import dispatch_queue_pkg::*;
#(
    parameter int XLEN = 64
);
    logic             fetch_ready_i;
    logic [31:0]      fetch_insn_i;
    logic             instruction_poll_o;
    logic             dispatch_valid_o;
    logic             dispatch_ready_i;
    e_functional_unit dispatch_fu_o;
    logic [31:0]      dispatch_insn_o;
    logic [4:0]       dispatch_rd_o;
    logic [4:0]       dispatch_rs1_o;
    logic [4:0]       dispatch_rs2_o;
    logic [XLEN-1:0]  dispatch_imm_o;
    logic             illegal_o;

    modport slave (
        input  fetch_ready_i, fetch_insn_i, dispatch_ready_i,
        output instruction_poll_o, dispatch_valid_o, dispatch_fu_o, dispatch_insn_o,
               dispatch_rd_o, dispatch_rs1_o, dispatch_rs2_o, dispatch_imm_o, illegal_o
    );

    modport master (
        output fetch_ready_i, fetch_insn_i, dispatch_ready_i,
        input  instruction_poll_o, dispatch_valid_o, dispatch_fu_o, dispatch_insn_o,
               dispatch_rd_o, dispatch_rs1_o, dispatch_rs2_o, dispatch_imm_o, illegal_o
    );
endinterface

// File: rtl/dispatch_queue_rv_decode.sv
// Combinational RV decoder: opcode to functional unit, register fields with
// format-based zeroing, and the sign-extended immediate.
module rv_decode
    import dispatch_queue_pkg::*;
(
    input  logic [31:0]     insn_i,
    output dispatch_entry_t entry_o,
    output logic            legal_o
);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    always_comb begin
        imm_i = {{20{insn_i[31]}}, insn_i[31:20]};
        imm_s = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
        imm_b = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
        imm_u = {insn_i[31:12], 12'b0};
        imm_j = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

        entry_o      = '0;
        entry_o.insn = insn_i;
        entry_o.rd   = insn_i[11:7];
        entry_o.rs1  = insn_i[19:15];
        entry_o.rs2  = insn_i[24:20];
        legal_o      = 1'b1;

        case (insn_i[6:0])
            OPC_OP, OPC_OP_32: begin
                entry_o.fu = ALU;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                entry_o.fu  = ALU;
                entry_o.rs2 = '0;
                entry_o.imm = sext32(imm_i);
            end
            OPC_LUI, OPC_AUIPC: begin
                entry_o.fu  = ALU;
                entry_o.rs1 = '0;
                entry_o.rs2 = '0;
                entry_o.imm = sext32(imm_u);
            end
            OPC_LOAD: begin
                entry_o.fu  = LSU;
                entry_o.rs2 = '0;
                entry_o.imm = sext32(imm_i);
            end
            OPC_STORE: begin
                entry_o.fu  = LSU;
                entry_o.rd  = '0;
                entry_o.imm = sext32(imm_s);
            end
            OPC_BRANCH: begin
                entry_o.fu  = BU;
                entry_o.rd  = '0;
                entry_o.imm = sext32(imm_b);
            end
            OPC_JAL: begin
                entry_o.fu  = BU;
                entry_o.rs1 = '0;
                entry_o.rs2 = '0;
                entry_o.imm = sext32(imm_j);
            end
            OPC_JALR: begin
                entry_o.fu  = BU;
                entry_o.rs2 = '0;
                entry_o.imm = sext32(imm_i);
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/dispatch_queue.sv
// Decode-and-dispatch stage: polls fetch, decodes, queues in order and issues
// one entry per cycle over valid/ready. No bypass and no pop-through when full.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    dispatch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    dispatch_entry_t mem_q [DEPTH];
    dispatch_entry_t mem_d [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic            illegal_q, illegal_d;

    dispatch_entry_t dec_entry, head_entry;
    logic            dec_legal;
    logic            poll, push, pop, valid;

    rv_decode u_decode (
        .insn_i  (bus.fetch_insn_i),
        .entry_o (dec_entry),
        .legal_o (dec_legal)
    );

    always_comb begin
        valid = (count_q != '0);
        // count never exceeds DEPTH, so its MSB alone means full
        poll  = bus.fetch_ready_i && !count_q[AW] && !illegal_q && !rst;
        push  = poll && dec_legal;
        pop   = valid && bus.dispatch_ready_i;

        head_entry = valid ? mem_q[head_q] : '0;

        mem_d = mem_q;
        if (push) mem_d[tail_q] = dec_entry;

        head_d = pop  ? head_q + AW'(1) : head_q;
        tail_d = push ? tail_q + AW'(1) : tail_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        illegal_d = illegal_q || (poll && !dec_legal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.instruction_poll_o = poll;
    assign bus.dispatch_valid_o   = valid;
    assign bus.dispatch_fu_o      = head_entry.fu;
    assign bus.dispatch_insn_o    = head_entry.insn;
    assign bus.dispatch_rd_o      = head_entry.rd;
    assign bus.dispatch_rs1_o     = head_entry.rs1;
    assign bus.dispatch_rs2_o     = head_entry.rs2;
    assign bus.dispatch_imm_o     = head_entry.imm[XLEN-1:0];
    assign bus.illegal_o          = illegal_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: hand-decoded expectations go into a
// scoreboard on each expected poll and are compared against the dispatch head.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispatch_queue_if #(.XLEN(64)) bus ();

    dispatch_queue #(.XLEN(64), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    dispatch_entry_t sb[$];
    dispatch_entry_t cur_ent;
    logic            cur_legal = 1'b1;
    logic            exp_ill   = 1'b0;

    dispatch_entry_t e_addi, e_sw, e_beq, e_lui, e_luin, e_jal, e_add, e_lw, e_bad;

    function automatic dispatch_entry_t mk(input e_functional_unit fu, input logic [31:0] insn,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [63:0] imm);
        dispatch_entry_t e;
        e.fu = fu; e.insn = insn; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input dispatch_entry_t e, input logic legal);
        bus.fetch_ready_i = 1'b1;
        bus.fetch_insn_i  = e.insn;
        cur_ent   = e;
        cur_legal = legal;
    endtask

    // One clock: check outputs at negedge, update scoreboard, return just after posedge.
    task automatic cycle(input logic exp_poll);
        @(negedge clk);
        chk("poll", 64'(bus.instruction_poll_o), 64'(exp_poll));
        chk("illegal", 64'(bus.illegal_o), 64'(exp_ill));
        if (sb.size() > 0) begin
            chk("valid", 64'(bus.dispatch_valid_o), 64'd1);
            chk("fu",    64'(bus.dispatch_fu_o),   64'(sb[0].fu));
            chk("insn",  64'(bus.dispatch_insn_o), 64'(sb[0].insn));
            chk("rd",    64'(bus.dispatch_rd_o),   64'(sb[0].rd));
            chk("rs1",   64'(bus.dispatch_rs1_o),  64'(sb[0].rs1));
            chk("rs2",   64'(bus.dispatch_rs2_o),  64'(sb[0].rs2));
            chk("imm",   bus.dispatch_imm_o,       sb[0].imm);
            if (bus.dispatch_ready_i) void'(sb.pop_front());
        end else begin
            chk("valid_idle", 64'(bus.dispatch_valid_o), 64'd0);
            chk("fu_idle",    64'(bus.dispatch_fu_o),    64'd0);
            chk("insn_idle",  64'(bus.dispatch_insn_o),  64'd0);
            chk("regs_idle",  64'({bus.dispatch_rd_o, bus.dispatch_rs1_o, bus.dispatch_rs2_o}), 64'd0);
            chk("imm_idle",   bus.dispatch_imm_o,        64'd0);
        end
        if (exp_poll && cur_legal)  sb.push_back(cur_ent);
        if (exp_poll && !cur_legal) exp_ill = 1'b1;
        if (rst) begin
            sb.delete();
            exp_ill = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_addi = mk(ALU, 32'h00500093, 5'd1, 5'd0, 5'd0, 64'd5);
        e_sw   = mk(LSU, 32'h0020A423, 5'd0, 5'd1, 5'd2, 64'd8);
        e_beq  = mk(BU,  32'hFE000EE3, 5'd0, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC);
        e_lui  = mk(ALU, 32'h123450B7, 5'd1, 5'd0, 5'd0, 64'h0000000012345000);
        e_luin = mk(ALU, 32'h800002B7, 5'd5, 5'd0, 5'd0, 64'hFFFFFFFF80000000);
        e_jal  = mk(BU,  32'hFF5FF0EF, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFF4);
        e_add  = mk(ALU, 32'h002081B3, 5'd3, 5'd1, 5'd2, 64'd0);
        e_lw   = mk(LSU, 32'hFF812283, 5'd5, 5'd2, 5'd0, 64'hFFFFFFFFFFFFFFF8);
        e_bad  = mk(ALU, 32'h00000000, 5'd0, 5'd0, 5'd0, 64'd0);

        // Reset with an instruction on offer: never polled
        bus.dispatch_ready_i = 1'b0;
        offer(e_addi, 1'b1);
        rst = 1'b1;
        #1;
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);

        // ALU / LSU / BU decode, one at a time, then a branch stall
        bus.dispatch_ready_i = 1'b1;
        offer(e_addi, 1'b1); cycle(1'b1);
        bus.fetch_ready_i = 1'b0; cycle(1'b0);
        offer(e_sw, 1'b1);   cycle(1'b1);
        bus.fetch_ready_i = 1'b0; cycle(1'b0);
        offer(e_beq, 1'b1);  cycle(1'b1);
        bus.fetch_ready_i = 1'b0; cycle(1'b0);
        cycle(1'b0);

        // Sustained push+pop, one per cycle
        offer(e_lui, 1'b1);  cycle(1'b1);
        offer(e_luin, 1'b1); cycle(1'b1);
        offer(e_jal, 1'b1);  cycle(1'b1);
        offer(e_add, 1'b1);  cycle(1'b1);
        offer(e_lw, 1'b1);   cycle(1'b1);
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);
        cycle(1'b0);

        // Fill to DEPTH with dispatch stalled, then no pop-through, then drain
        bus.dispatch_ready_i = 1'b0;
        offer(e_addi, 1'b1); cycle(1'b1);
        offer(e_sw, 1'b1);   cycle(1'b1);
        offer(e_beq, 1'b1);  cycle(1'b1);
        offer(e_jal, 1'b1);  cycle(1'b1);
        offer(e_add, 1'b1);  cycle(1'b0);
        cycle(1'b0);
        bus.dispatch_ready_i = 1'b1;
        cycle(1'b0);
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);

        // Illegal opcode with entries queued: sticky, blocks polls, queue drains
        bus.dispatch_ready_i = 1'b0;
        offer(e_addi, 1'b1); cycle(1'b1);
        offer(e_sw, 1'b1);   cycle(1'b1);
        offer(e_bad, 1'b0);  cycle(1'b1);
        offer(e_lui, 1'b1);  cycle(1'b0);
        bus.dispatch_ready_i = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b1;
        cycle(1'b0);
        rst = 1'b0;
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);

        // Reset mid-operation discards three queued entries
        bus.dispatch_ready_i = 1'b0;
        offer(e_jal, 1'b1);  cycle(1'b1);
        offer(e_lw, 1'b1);   cycle(1'b1);
        offer(e_luin, 1'b1); cycle(1'b1);
        offer(e_add, 1'b1);
        rst = 1'b1;
        cycle(1'b0);
        rst = 1'b0;
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);

        // Normal operation resumes after reset
        bus.dispatch_ready_i = 1'b1;
        offer(e_add, 1'b1);  cycle(1'b1);
        bus.fetch_ready_i = 1'b0;
        cycle(1'b0);
        cycle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
